// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry skid buffer
// Streams 64-bit bundles to decode, absorbing decode stalls and redirects.
module fetch_unit #(
  parameter int          ADDR_W   = 15,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interlock,
  input  logic              branch_flag,
  input  logic [31:0]       branch_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [63:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [63:0]       inst
);

  localparam logic [5:0]  NOP_OP     = 6'h3F;
  localparam logic [63:0] NOP_BUNDLE = {NOP_OP, 26'b0, NOP_OP, 26'b0};

  // STREAM: a read is in flight; HELD: the skid buffer owns the next bundle.
  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_STREAM = 2'd1,
    S_HELD   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [63:0] skid_inst_q, skid_inst_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] inst_q, inst_d;
  logic        fetch_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      fpc_q       <= RESET_PC;
      req_pc_q    <= 32'h0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= NOP_BUNDLE;
      pc_q        <= 32'h0;
      inst_q      <= NOP_BUNDLE;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      req_pc_q    <= req_pc_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    req_pc_d    = req_pc_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    fetch_req   = 1'b0;
    imem_addr   = fpc_q[ADDR_W-1:0];

    if (branch_flag) begin
      // Redirect wins over a stall; in-flight read and skid contents are dropped.
      fetch_req = 1'b1;
      imem_addr = branch_pc[ADDR_W-1:0];
      fpc_d     = branch_pc + 32'd1;
      req_pc_d  = branch_pc;
      state_d   = S_STREAM;
      pc_d      = 32'h0;
      inst_d    = NOP_BUNDLE;
    end else if (!interlock) begin
      fetch_req = 1'b1;
      fpc_d     = fpc_q + 32'd1;
      req_pc_d  = fpc_q;
      state_d   = S_STREAM;
      case (state_q)
        S_HELD: begin
          pc_d   = skid_pc_q;
          inst_d = skid_inst_q;
        end
        S_STREAM: begin
          pc_d   = req_pc_q;
          inst_d = imem_rdata;
        end
        default: begin
          pc_d   = 32'h0;
          inst_d = NOP_BUNDLE;
        end
      endcase
    end else if (state_q == S_STREAM) begin
      // Read data is only valid this cycle, so park it until decode frees up.
      skid_pc_d   = req_pc_q;
      skid_inst_d = imem_rdata;
      state_d     = S_HELD;
    end

    imem_en = fetch_req & ~rst;
  end

  assign pc   = pc_q;
  assign inst = inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a bundle-stream model
module tb_fetch_unit;

  localparam int          AW       = 4;
  localparam logic [31:0] RST_PC   = 32'h0;
  localparam logic [63:0] NOP_BNDL = {6'h3F, 26'b0, 6'h3F, 26'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic          interlock;
  logic          branch_flag;
  logic [31:0]   branch_pc;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [63:0]   imem_rdata = 64'h0;
  logic [31:0]   pc;
  logic [63:0]   inst;

  int checks = 0;
  int errors = 0;

  // Model: the bundle stream as seen by decode. m_nxt is the next bundle
  // decode will receive; m_avail says whether its fetch has already been issued.
  logic          m_avail;
  logic [31:0]   m_nxt;
  logic [31:0]   m_pc;
  logic [63:0]   m_inst;
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  logic          obs_en;
  logic [AW-1:0] obs_addr;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .interlock  (interlock),
    .branch_flag(branch_flag),
    .branch_pc  (branch_pc),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .inst       (inst)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_data(input logic [AW-1:0] a);
    return 64'(a) * 64'h0101;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_data(imem_addr);
  end

  task automatic model_reset();
    m_avail = 1'b0;
    m_nxt   = RST_PC;
    m_pc    = 32'h0;
    m_inst  = NOP_BNDL;
  endtask

  // Called at a falling edge; returns at the next falling edge with the model advanced.
  task automatic cycle(input logic il, input logic br, input logic [31:0] bpc);
    logic [31:0] fa;
    interlock   = il;
    branch_flag = br;
    branch_pc   = bpc;
    fa          = br ? bpc : (m_avail ? m_nxt + 32'd1 : m_nxt);
    exp_en      = br | ~il;
    exp_addr    = fa[AW-1:0];
    #1;
    obs_en   = imem_en;
    obs_addr = imem_addr;
    @(posedge clk);
    if (br) begin
      m_pc    = 32'h0;
      m_inst  = NOP_BNDL;
      m_nxt   = bpc;
      m_avail = 1'b1;
    end else if (!il) begin
      if (m_avail) begin
        m_pc   = m_nxt;
        m_inst = mem_data(m_nxt[AW-1:0]);
        m_nxt  = m_nxt + 32'd1;
      end else begin
        m_pc    = 32'h0;
        m_inst  = NOP_BNDL;
        m_avail = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; interlock = 1'b0; branch_flag = 1'b0; branch_pc = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 32'h0 || inst !== NOP_BNDL || imem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h inst=%h en=%b expected pc=0 inst=%h en=0", pc, inst, imem_en, NOP_BNDL);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ep;
      logic [63:0] ei;
      logic [31:0] ea;
      cycle(1'b0, 1'b0, 32'h0);
      ep = (i == 0) ? 32'h0 : 32'(i - 1);
      ei = (i == 0) ? NOP_BNDL : mem_data(ep[AW-1:0]);
      ea = 32'(i);
      checks++;
      if (pc !== ep || inst !== ei || obs_en !== 1'b1 || obs_addr !== ea[AW-1:0]) begin
        errors++;
        $display("FAIL reset_release[%0d]: pc=%h inst=%h en=%b addr=%h expected pc=%h inst=%h en=1 addr=%h",
                 i, pc, inst, obs_en, obs_addr, ep, ei, ea[AW-1:0]);
      end
    end
  endtask

  task automatic test_interlock();
    int n = 0;
    while (m_pc != 32'd5 && n < 40) begin cycle(1'b0, 1'b0, 32'h0); n++; end
    checks++;
    if (pc !== 32'd5) begin
      errors++;
      $display("FAIL interlock_reach: pc=%h expected 5", pc);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (pc !== 32'd5 || inst !== mem_data(4'd5) || obs_en !== 1'b0) begin
        errors++;
        $display("FAIL interlock_hold[%0d]: pc=%h inst=%h en=%b expected pc=5 inst=%h en=0", i, pc, inst, obs_en, mem_data(4'd5));
      end
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ep;
      cycle(1'b0, 1'b0, 32'h0);
      ep = 32'(6 + i);
      checks++;
      if (pc !== ep || inst !== mem_data(ep[AW-1:0])) begin
        errors++;
        $display("FAIL interlock_release[%0d]: pc=%h inst=%h expected pc=%h inst=%h", i, pc, inst, ep, mem_data(ep[AW-1:0]));
      end
    end
  endtask

  task automatic test_branch();
    int n = 0;
    while (m_pc != 32'd10 && n < 40) begin cycle(1'b0, 1'b0, 32'h0); n++; end
    checks++;
    if (pc !== 32'd10) begin
      errors++;
      $display("FAIL branch_reach: pc=%h expected a", pc);
    end
    cycle(1'b0, 1'b1, 32'h40);
    checks++;
    if (pc !== 32'h0 || inst !== NOP_BNDL || obs_en !== 1'b1 || obs_addr !== 4'h0) begin
      errors++;
      $display("FAIL branch_bubble: pc=%h inst=%h en=%b addr=%h expected pc=0 NOP en=1 addr=0", pc, inst, obs_en, obs_addr);
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h40 || inst !== mem_data(4'h0) || obs_addr !== 4'h1) begin
      errors++;
      $display("FAIL branch_target: pc=%h inst=%h addr=%h expected pc=40 inst=%h addr=1", pc, inst, obs_addr, mem_data(4'h0));
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h41 || inst !== mem_data(4'h1)) begin
      errors++;
      $display("FAIL branch_next: pc=%h inst=%h expected pc=41 inst=%h", pc, inst, mem_data(4'h1));
    end
  endtask

  task automatic test_branch_during_stall();
    logic [31:0] held;
    cycle(1'b0, 1'b0, 32'h0);
    held = m_pc;
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (pc !== held) begin
      errors++;
      $display("FAIL stall_branch_hold: pc=%h expected %h", pc, held);
    end
    cycle(1'b1, 1'b1, 32'h123);
    checks++;
    if (pc !== 32'h0 || inst !== NOP_BNDL || obs_en !== 1'b1 || obs_addr !== 4'h3) begin
      errors++;
      $display("FAIL stall_branch_bubble: pc=%h inst=%h en=%b addr=%h expected pc=0 NOP en=1 addr=3", pc, inst, obs_en, obs_addr);
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h123 || inst !== mem_data(4'h3)) begin
      errors++;
      $display("FAIL stall_branch_target: pc=%h inst=%h expected pc=123 inst=%h", pc, inst, mem_data(4'h3));
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h124 || inst !== mem_data(4'h4)) begin
      errors++;
      $display("FAIL stall_branch_next: pc=%h inst=%h expected pc=124 inst=%h", pc, inst, mem_data(4'h4));
    end
  endtask

  task automatic test_addr_wrap();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (i == 15) begin
        checks++;
        if (obs_addr !== 4'hF) begin
          errors++;
          $display("FAIL wrap_addr_15: addr=%h expected f", obs_addr);
        end
      end
      if (i == 16) begin
        checks++;
        if (obs_addr !== 4'h0 || pc !== 32'd15) begin
          errors++;
          $display("FAIL wrap_addr_0: addr=%h pc=%h expected addr=0 pc=f", obs_addr, pc);
        end
      end
      if (i == 17) begin
        checks++;
        if (pc !== 32'd16 || inst !== mem_data(4'h0)) begin
          errors++;
          $display("FAIL wrap_pc_16: pc=%h inst=%h expected pc=10 inst=%h", pc, inst, mem_data(4'h0));
        end
      end
    end
  endtask

  task automatic test_reset_in_held();
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0 || inst !== NOP_BNDL || imem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_held: pc=%h inst=%h en=%b expected pc=0 NOP en=0", pc, inst, imem_en);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ep;
      logic [63:0] ei;
      cycle(1'b0, 1'b0, 32'h0);
      ep = (i == 0) ? 32'h0 : 32'(i - 1);
      ei = (i == 0) ? NOP_BNDL : mem_data(ep[AW-1:0]);
      checks++;
      if (pc !== ep || inst !== ei) begin
        errors++;
        $display("FAIL reset_restart[%0d]: pc=%h inst=%h expected pc=%h inst=%h", i, pc, inst, ep, ei);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic il;
      logic br;
      il = ($urandom % 10) < 4;
      br = ($urandom % 12) == 0;
      cycle(il, br, $urandom);
      checks++;
      if (pc !== m_pc || inst !== m_inst || obs_en !== exp_en || (exp_en && obs_addr !== exp_addr)) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h inst=%h en=%b addr=%h expected pc=%h inst=%h en=%b addr=%h",
                 i, pc, inst, obs_en, obs_addr, m_pc, m_inst, exp_en, exp_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_interlock();
    test_branch();
    test_branch_during_stall();
    test_addr_wrap();
    test_reset_in_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
